// File: rtl/lift_pkg.sv
// Shared lift definitions: scheduler state encoding and the default floor
// geometry used by both the call scheduler and the lift motion block.
package lift_pkg;

  localparam int NUM_FLOORS  = 7;
  localparam int FLOOR_W     = 3;
  localparam int DOOR_CYCLES = 4;

  typedef logic [1:0] lift_state_t;

  localparam lift_state_t ST_IDLE     = 2'd0;
  localparam lift_state_t ST_DISPATCH = 2'd1;
  localparam lift_state_t ST_MOVING   = 2'd2;
  localparam lift_state_t ST_DOOR     = 2'd3;

endpackage

// File: rtl/lift_target_pick.sv
// Combinational SCAN target selection: nearest pending floor in the current
// sweep direction, reversing the sweep only when nothing lies ahead.
module lift_target_pick
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS = lift_pkg::NUM_FLOORS,
  parameter int FLOOR_W    = lift_pkg::FLOOR_W
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    car_floor,
  input  logic                  dir_up,
  output logic                  hit_here,
  output logic [FLOOR_W-1:0]    target,
  output logic                  new_dir_up,
  output logic                  found
);

  logic [NUM_FLOORS-1:0] above_hit_s;
  logic [NUM_FLOORS-1:0] below_hit_s;
  logic [NUM_FLOORS-1:0] here_hit_s;
  logic [FLOOR_W-1:0]    above_s;
  logic [FLOOR_W-1:0]    below_s;
  logic                  above_ok_s;
  logic                  below_ok_s;

  // Split pending floors into above / below / at the car.
  always_comb begin
    for (int k = 0; k < NUM_FLOORS; k++) begin
      above_hit_s[k] = pending[k] && (FLOOR_W'(k + 1) > car_floor);
      below_hit_s[k] = pending[k] && (FLOOR_W'(k + 1) < car_floor);
      here_hit_s[k]  = pending[k] && (FLOOR_W'(k + 1) == car_floor);
    end
  end

  // Priority encoders: lowest floor above wins, highest floor below wins.
  always_comb begin
    above_s = '0;
    below_s = '0;
    for (int k = NUM_FLOORS - 1; k >= 0; k--) begin
      above_s = above_hit_s[k] ? FLOOR_W'(k + 1) : above_s;
    end
    for (int k = 0; k < NUM_FLOORS; k++) begin
      below_s = below_hit_s[k] ? FLOOR_W'(k + 1) : below_s;
    end
    above_ok_s = |above_hit_s;
    below_ok_s = |below_hit_s;
  end

  // Direction-preserving choice; a reversal only happens when the way ahead is empty.
  always_comb begin
    hit_here = |here_hit_s;
    found    = above_ok_s | below_ok_s;
    if (dir_up && above_ok_s) begin
      target     = above_s;
      new_dir_up = 1'b1;
    end else if (!dir_up && below_ok_s) begin
      target     = below_s;
      new_dir_up = 1'b0;
    end else if (above_ok_s) begin
      target     = above_s;
      new_dir_up = 1'b1;
    end else if (below_ok_s) begin
      target     = below_s;
      new_dir_up = 1'b0;
    end else begin
      target     = '0;
      new_dir_up = dir_up;
    end
  end

endmodule

// File: rtl/lift_call_scheduler.sv
// Lift call scheduler: latches floor calls, dispatches SCAN targets over a
// valid/ready handshake and times the door-open interval after each stop.
module lift_call_scheduler
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS  = lift_pkg::NUM_FLOORS,
  parameter int FLOOR_W     = lift_pkg::FLOOR_W,
  parameter int DOOR_CYCLES = lift_pkg::DOOR_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] hall_call_i,
  input  logic [NUM_FLOORS-1:0] car_call_i,
  input  logic [FLOOR_W-1:0]    car_floor_i,
  input  logic                  arrived_i,
  input  logic                  target_ready_i,
  output logic [FLOOR_W-1:0]    target_o,
  output logic                  target_valid_o,
  output logic                  door_open_o,
  output logic                  dir_up_o,
  output logic [NUM_FLOORS-1:0] pending_o,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int CNT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DOOR_CYCLES - 1);

  lift_state_t           state_r,   state_nxt_s;
  logic [NUM_FLOORS-1:0] pending_r, pending_nxt_s;
  logic [FLOOR_W-1:0]    target_r,  target_nxt_s;
  logic                  valid_r,   valid_nxt_s;
  logic                  door_r,    door_nxt_s;
  logic                  dir_r,     dir_nxt_s;
  logic                  busy_r,    busy_nxt_s;
  logic                  err_r,     err_nxt_s;
  logic [CNT_W-1:0]      cnt_r,     cnt_nxt_s;

  logic [NUM_FLOORS-1:0] here_mask_s;
  logic [NUM_FLOORS-1:0] tgt_mask_s;
  logic [NUM_FLOORS-1:0] clr_s;
  logic                  floor_bad_s;
  logic                  hit_here_s;
  logic                  found_s;
  logic [FLOOR_W-1:0]    pick_target_s;
  logic                  pick_dir_s;

  lift_target_pick #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_pick (
    .pending    (pending_r),
    .car_floor  (car_floor_i),
    .dir_up     (dir_r),
    .hit_here   (hit_here_s),
    .target     (pick_target_s),
    .new_dir_up (pick_dir_s),
    .found      (found_s)
  );

  // One-hot decode of the car floor and the dispatched target; out-of-range floors decode to zero.
  always_comb begin
    for (int k = 0; k < NUM_FLOORS; k++) begin
      here_mask_s[k] = (car_floor_i == FLOOR_W'(k + 1));
      tgt_mask_s[k]  = (target_r == FLOOR_W'(k + 1));
    end
    floor_bad_s = (car_floor_i != target_r) || (car_floor_i == '0) ||
                  (car_floor_i > FLOOR_W'(NUM_FLOORS));
  end

  // Scheduler FSM next-state; served floors are cleared after new calls are merged so clear wins.
  always_comb begin
    state_nxt_s  = state_r;
    target_nxt_s = target_r;
    valid_nxt_s  = valid_r;
    door_nxt_s   = door_r;
    dir_nxt_s    = dir_r;
    err_nxt_s    = err_r;
    cnt_nxt_s    = cnt_r;
    clr_s        = '0;
    case (state_r)
      ST_IDLE: begin
        if (pending_r == '0) begin
          state_nxt_s = ST_IDLE;
        end else if (hit_here_s) begin
          clr_s       = here_mask_s;
          state_nxt_s = ST_DOOR;
          door_nxt_s  = 1'b1;
          cnt_nxt_s   = CNT_LOAD;
        end else if (found_s) begin
          target_nxt_s = pick_target_s;
          dir_nxt_s    = pick_dir_s;
          valid_nxt_s  = 1'b1;
          state_nxt_s  = ST_DISPATCH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DISPATCH: begin
        if (target_ready_i) begin
          valid_nxt_s = 1'b0;
          state_nxt_s = ST_MOVING;
        end else begin
          valid_nxt_s = 1'b1;
        end
      end
      ST_MOVING: begin
        if (arrived_i) begin
          clr_s       = tgt_mask_s;
          err_nxt_s   = err_r | floor_bad_s;
          state_nxt_s = ST_DOOR;
          door_nxt_s  = 1'b1;
          cnt_nxt_s   = CNT_LOAD;
        end else begin
          state_nxt_s = ST_MOVING;
        end
      end
      ST_DOOR: begin
        // Calls at the open door are absorbed rather than latched.
        clr_s = here_mask_s;
        if (cnt_r == '0) begin
          state_nxt_s = ST_IDLE;
          door_nxt_s  = 1'b0;
        end else begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        valid_nxt_s = 1'b0;
        door_nxt_s  = 1'b0;
      end
    endcase
    pending_nxt_s = (pending_r | hall_call_i | car_call_i) & ~clr_s;
    busy_nxt_s    = (state_nxt_s != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      pending_r <= '0;
      target_r  <= '0;
      valid_r   <= 1'b0;
      door_r    <= 1'b0;
      dir_r     <= 1'b1;
      busy_r    <= 1'b0;
      err_r     <= 1'b0;
      cnt_r     <= '0;
    end else begin
      state_r   <= state_nxt_s;
      pending_r <= pending_nxt_s;
      target_r  <= target_nxt_s;
      valid_r   <= valid_nxt_s;
      door_r    <= door_nxt_s;
      dir_r     <= dir_nxt_s;
      busy_r    <= busy_nxt_s;
      err_r     <= err_nxt_s;
      cnt_r     <= cnt_nxt_s;
    end
  end

  assign target_o       = target_r;
  assign target_valid_o = valid_r;
  assign door_open_o    = door_r;
  assign dir_up_o       = dir_r;
  assign pending_o      = pending_r;
  assign busy_o         = busy_r;
  assign err_o          = err_r;

endmodule

// File: tb/tb_lift_call_scheduler.sv
// Bench for lift_call_scheduler: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_lift_call_scheduler;

  localparam int NF = 7;
  localparam int FW = 3;
  localparam int DC = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NF-1:0] hall_call = '0;
  logic [NF-1:0] car_call = '0;
  logic [FW-1:0] car_floor = 3'd1;
  logic          arrived = 1'b0;
  logic          target_ready = 1'b0;
  logic [FW-1:0] target_o;
  logic          target_valid_o;
  logic          door_open_o;
  logic          dir_up_o;
  logic [NF-1:0] pending_o;
  logic          busy_o;
  logic          err_o;

  always #5 clk = ~clk;

  lift_call_scheduler #(
    .NUM_FLOORS  (NF),
    .FLOOR_W     (FW),
    .DOOR_CYCLES (DC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .hall_call_i    (hall_call),
    .car_call_i     (car_call),
    .car_floor_i    (car_floor),
    .arrived_i      (arrived),
    .target_ready_i (target_ready),
    .target_o       (target_o),
    .target_valid_o (target_valid_o),
    .door_open_o    (door_open_o),
    .dir_up_o       (dir_up_o),
    .pending_o      (pending_o),
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Behavioural model: mode 0 idle, 1 offering target, 2 travelling, 3 door open.
  int        m_mode;
  bit [NF:1] m_pend;
  int        m_target;
  bit        m_valid, m_door, m_dir, m_err;
  int        m_door_left;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pend = '0; m_target = 0; m_valid = 1'b0;
    m_door = 1'b0; m_dir = 1'b1; m_err = 1'b0; m_door_left = 0;
  endtask

  function automatic int nearest(input bit [NF:1] p, input int cf, input bit up);
    int best, bd, d;
    best = 0; bd = 1000;
    for (int f = 1; f <= NF; f++) begin
      if (p[f] && (up ? (f > cf) : (f < cf))) begin
        d = up ? (f - cf) : (cf - f);
        if (d < bd) begin bd = d; best = f; end
      end
    end
    return best;
  endfunction

  task automatic model_step();
    int cf, pick;
    bit [NF:1] calls, clr;
    cf = int'(car_floor);
    calls = hall_call | car_call;
    clr = '0;
    case (m_mode)
      0: if (m_pend != '0) begin
        if (cf >= 1 && cf <= NF && m_pend[cf]) begin
          clr[cf] = 1'b1; m_mode = 3; m_door = 1'b1; m_door_left = DC;
        end else begin
          pick = nearest(m_pend, cf, m_dir);
          if (pick == 0) begin
            m_dir = !m_dir;
            pick = nearest(m_pend, cf, m_dir);
          end
          m_target = pick; m_valid = 1'b1; m_mode = 1;
        end
      end
      1: if (target_ready) begin m_valid = 1'b0; m_mode = 2; end
      2: if (arrived) begin
        clr[m_target] = 1'b1;
        if (cf != m_target || cf < 1 || cf > NF) m_err = 1'b1;
        m_mode = 3; m_door = 1'b1; m_door_left = DC;
      end
      3: begin
        if (cf >= 1 && cf <= NF) clr[cf] = 1'b1;
        m_door_left--;
        if (m_door_left == 0) begin m_mode = 0; m_door = 1'b0; end
      end
      default: m_mode = 0;
    endcase
    m_pend = (m_pend | calls) & ~clr;
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("target_o", 32'(target_o), 32'(m_target));
      check("target_valid_o", 32'(target_valid_o), 32'(m_valid));
      check("door_open_o", 32'(door_open_o), 32'(m_door));
      check("dir_up_o", 32'(dir_up_o), 32'(m_dir));
      check("pending_o", 32'(pending_o), 32'(m_pend));
      check("busy_o", 32'(busy_o), 32'(m_mode != 0));
      check("err_o", 32'(err_o), 32'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step(); else model_reset();
    #1;
    hall_call = '0; car_call = '0; arrived = 1'b0;
  endtask

  task automatic do_reset();
    #1;
    rst_n = 1'b0; target_ready = 1'b0;
    model_reset();
    tick();
    #1;
    rst_n = 1'b1;
  endtask

  task automatic dispatch_and_accept(input int floor_idx);
    hall_call[floor_idx] = 1'b1;
    tick();
    tick();
    target_ready = 1'b1;
    tick();
    target_ready = 1'b0;
  endtask

  int door_cnt;

  initial begin
    model_reset();
    tick();
    chk_en = 1'b1;
    tick();
    #1 rst_n = 1'b1;

    // Single call: floor 5 from floor 1.
    car_floor = 3'd1;
    hall_call[4] = 1'b1;
    tick();
    check("t_single_pend", 32'(pending_o), 32'(7'b0010000));
    check("t_single_valid_early", 32'(target_valid_o), 32'd0);
    tick();
    check("t_single_target", 32'(target_o), 32'd5);
    check("t_single_valid", 32'(target_valid_o), 32'd1);
    target_ready = 1'b1;
    tick();
    target_ready = 1'b0;
    check("t_single_dropped", 32'(target_valid_o), 32'd0);
    tick();
    car_floor = 3'd5; arrived = 1'b1;
    tick();
    door_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (door_open_o) door_cnt++;
      tick();
    end
    check("t_single_door_cycles", 32'(door_cnt), 32'd4);
    check("t_single_cleared", 32'(pending_o[4]), 32'd0);

    // Reset mid-MOVING with two calls outstanding.
    car_floor = 3'd1;
    dispatch_and_accept(4);
    car_call[1] = 1'b1;
    tick();
    check("t_rst_pre_pend", 32'(pending_o), 32'(7'b0010010));
    check("t_rst_pre_busy", 32'(busy_o), 32'd1);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("t_rst_pend", 32'(pending_o), 32'd0);
    check("t_rst_target", 32'(target_o), 32'd0);
    check("t_rst_valid", 32'(target_valid_o), 32'd0);
    check("t_rst_door", 32'(door_open_o), 32'd0);
    check("t_rst_dir", 32'(dir_up_o), 32'd1);
    check("t_rst_busy", 32'(busy_o), 32'd0);
    check("t_rst_err", 32'(err_o), 32'd0);
    tick();
    #1 rst_n = 1'b1;

    // SCAN order: car at 4 going up, calls for 2 and 6.
    do_reset();
    car_floor = 3'd4;
    car_call = 7'b0100010;
    tick();
    tick();
    check("t_scan_first", 32'(target_o), 32'd6);
    check("t_scan_dir_up", 32'(dir_up_o), 32'd1);
    target_ready = 1'b1;
    tick();
    target_ready = 1'b0;
    tick();
    car_floor = 3'd6; arrived = 1'b1;
    tick();
    for (int i = 0; i < 20 && !target_valid_o; i++) tick();
    check("t_scan_second_valid", 32'(target_valid_o), 32'd1);
    check("t_scan_second", 32'(target_o), 32'd2);
    check("t_scan_dir_down", 32'(dir_up_o), 32'd0);

    // Call at the current floor goes straight to DOOR.
    do_reset();
    car_floor = 3'd3;
    hall_call[2] = 1'b1;
    tick();
    tick();
    check("t_here_door", 32'(door_open_o), 32'd1);
    door_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (target_valid_o) door_cnt++;
      tick();
    end
    check("t_here_no_valid", 32'(door_cnt), 32'd0);
    check("t_here_cleared", 32'(pending_o), 32'd0);

    // Backpressure: ready held low for 10 cycles.
    do_reset();
    car_floor = 3'd1;
    hall_call[6] = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      check("t_bp_target", 32'(target_o), 32'd7);
      check("t_bp_valid", 32'(target_valid_o), 32'd1);
      tick();
    end
    target_ready = 1'b1;
    tick();
    target_ready = 1'b0;
    check("t_bp_dropped", 32'(target_valid_o), 32'd0);
    check("t_bp_moving", 32'(busy_o), 32'd1);

    // Arrival reported at floor 0 while target is 5.
    do_reset();
    car_floor = 3'd1;
    dispatch_and_accept(4);
    car_floor = 3'd0; arrived = 1'b1;
    tick();
    check("t_err_set", 32'(err_o), 32'd1);
    check("t_err_cleared_bit", 32'(pending_o[4]), 32'd0);
    for (int i = 0; i < 10; i++) tick();
    check("t_err_sticky", 32'(err_o), 32'd1);

    // Randomized traffic with a lift emulator driven from the model state.
    do_reset();
    car_floor = 3'd1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ($urandom_range(0, 7) == 0) hall_call[$urandom_range(0, NF - 1)] = 1'b1;
      if ($urandom_range(0, 9) == 0) car_call[$urandom_range(0, NF - 1)] = 1'b1;
      target_ready = (m_mode == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
      if (m_mode == 2 && $urandom_range(0, 3) == 0) begin
        arrived = 1'b1;
        car_floor = ($urandom_range(0, 49) == 0) ? FW'($urandom_range(0, 7)) : FW'(m_target);
      end else if (m_mode != 2 && $urandom_range(0, 19) == 0) begin
        arrived = 1'b1;
      end
      if (m_mode == 0 && $urandom_range(0, 29) == 0) car_floor = FW'($urandom_range(0, 7));
      if ($urandom_range(0, 799) == 0) begin
        #1 rst_n = 1'b0;
        model_reset();
        tick();
        #1 rst_n = 1'b1;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lift_call_scheduler.md
# lift_call_scheduler

Call scheduler for the lift car. Latches hall and in-car floor calls, picks the next target floor with a direction-preserving (SCAN) policy, and hands targets to the car datapath over a valid/ready handshake. After each arrival it times the door-open interval. Sits between the floor/car button inputs and the lift motion block.

## Interface
- NUM_FLOORS, 7: number of floors; floors are numbered 1..NUM_FLOORS, 0 is invalid.
- FLOOR_W, 3: floor number width; must satisfy 2^FLOOR_W > NUM_FLOORS.
- DOOR_CYCLES, 4: number of cycles the door is held open at each stop (at least 1).

- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- hall_call_i  in  NUM_FLOORS  hall call pulses; bit k is floor k+1.
- car_call_i  in  NUM_FLOORS  in-car button pulses; bit k is floor k+1.
- car_floor_i  in  FLOOR_W  current car floor, driven by the lift.
- arrived_i  in  1  one-cycle pulse: the car has stopped at target_o.
- target_ready_i  in  1  lift accepts target_o.
- target_o  out  FLOOR_W  requested target floor.
- target_valid_o  out  1  target_o is valid.
- door_open_o  out  1  door open indication.
- dir_up_o  out  1  current sweep direction (1 = up).
- pending_o  out  NUM_FLOORS  latched outstanding calls.
- busy_o  out  1  high in any state other than IDLE.
- err_o  out  1  sticky flag: arrived_i seen while car_floor_i is out of range, or car_floor_i != target_o at arrival.

## Operation
- pending = pending | hall_call_i | car_call_i on every cycle.
- A bit is cleared when its floor is served. On the same bit in the same cycle, clear wins over set.
- State IDLE:
  - If pending is empty, stay in IDLE.
  - Else if pending has the bit for car_floor_i: clear that bit and go to DOOR.
  - Else pick the nearest pending floor in the dir_up_o direction. If there is none in that direction, invert dir_up_o and pick the nearest in the new direction. Register the result into target_o and go to DISPATCH.
- State DISPATCH:
  - target_valid_o = 1. target_o is held stable until target_ready_i is seen.
  - On valid && ready, go to MOVING.
- State MOVING:
  - Wait for arrived_i.
  - The target is never re-issued. Calls collected on the way are served on later passes.
  - On arrived_i: clear the bit for target_o and go to DOOR.
  - If car_floor_i != target_o, or car_floor_i is 0 or greater than NUM_FLOORS, set err_o. The bit for target_o is still cleared.
- State DOOR:
  - door_open_o = 1. A down-counter is loaded with DOOR_CYCLES-1 on entry.
  - Calls for car_floor_i that arrive while in DOOR are absorbed and never latched.
  - When the counter reaches 0, go to IDLE.
- Floor arithmetic is unsigned FLOOR_W-bit. Nearest-floor search is done only over 1..NUM_FLOORS, so no wrap-around is possible.

## Timing
- Reset values: state IDLE, pending_o 0, target_o 0, target_valid_o 0, door_open_o 0, dir_up_o 1, busy_o 0, err_o 0. err_o is cleared only by reset.
- Reset is allowed mid-operation, including mid-handshake. All state is cleared asynchronously; outstanding calls are lost.
- A call pulse at cycle n appears in pending_o at n+1.
- From IDLE, target_valid_o rises at n+2 after the call pulse.
- A call at the current floor while in IDLE raises door_open_o at n+2, with no handshake.
- arrived_i at cycle m gives door_open_o high for cycles m+1 .. m+DOOR_CYCLES. The state is IDLE at m+DOOR_CYCLES+1, and the earliest next target_valid_o is at m+DOOR_CYCLES+2.
- Handshake rules:
  - target_valid_o stays high until accepted; it drops the cycle after valid && ready.
  - target_ready_i is ignored outside DISPATCH.
  - arrived_i is ignored outside MOVING.
- All outputs are registered.

## Structure
- Shared package lift_pkg holds:
  - the state encoding IDLE/DISPATCH/MOVING/DOOR as a 2-bit typedef;
  - the default floor constants NUM_FLOORS and FLOOR_W, shared with the lift motion block.
- Sub-module lift_target_pick is combinational. Inputs: pending, car_floor, dir_up. Outputs: hit_here, target, new_dir_up, found. It computes the nearest-above and nearest-below searches using priority encoders over masked pending bits.
- The FSM, pending register, and door counter live in the top module.

## Test plan
- Reset: assert rst_n low mid-MOVING with pending 0b0010010. The next sampled cycle shows every output at its reset value and pending_o = 0.
- Single call: car_floor_i=1, pulse hall_call_i[4]. pending_o=0b0010000 one cycle later; target_o=5 with target_valid_o two cycles later. Accept it, pulse arrived_i with car_floor_i=5. door_open_o is high for exactly 4 cycles, and pending_o[4] is cleared.
- SCAN order: car at 4, dir_up_o=1, car_call_i bits for floors 2 and 6 in the same cycle. Targets are 6 first, then 2, and dir_up_o becomes 0 on the second dispatch.
- Current-floor call: car_floor_i=3 while in IDLE, pulse hall_call_i[2]. The block enters DOOR, target_valid_o never rises, and the bit is cleared.
- Backpressure: hold target_ready_i low for 10 cycles in DISPATCH. target_o and target_valid_o stay stable; the block moves to MOVING the cycle after ready rises.
- Error: pulse arrived_i with car_floor_i=0 while target_o=5. err_o=1 and stays set; pending_o[4] is cleared.
